// File: rtl/handshake_ready_skid.sv
`default_nettype none
// ============================================================================
//  Module      : handshake_ready_skid
//  Description : Ready-path register slice for a valid/ready stream, built
//                as a 2-entry skid buffer. up_ready is always a flop output,
//                so the combinational down_ready -> up_ready path is cut.
//                Lossless, order-preserving, full rate without bubbles.
//
//  Configuration macro : HS_SKID_FWD_REG_EN
//      undefined : forward path is combinational (0-cycle latency), a single
//                  skid register absorbs the word in flight when the
//                  consumer stalls; occupancy 0..1.
//      defined   : forward path is registered as well (1-cycle latency),
//                  output register plus skid register under a 3-state FSM;
//                  occupancy 0..2.
//
//  Ports
//      clk         in   1           single clock, posedge
//      rst         in   1           synchronous reset, active-high
//      up_valid    in   1           upstream word valid
//      up_data     in   WORD_WIDTH  upstream payload
//      up_ready    out  1           registered ready to upstream
//      down_valid  out  1           downstream word valid
//      down_data   out  WORD_WIDTH  downstream payload
//      down_ready  in   1           downstream ready
//      occupancy   out  2           words held internally (debug)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module handshake_ready_skid #(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  up_valid,
    input  logic [WORD_WIDTH-1:0] up_data,
    output logic                  up_ready,
    output logic                  down_valid,
    output logic [WORD_WIDTH-1:0] down_data,
    input  logic                  down_ready,
    output logic [1:0]            occupancy
);

`ifdef HS_SKID_FWD_REG_EN

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_up_ready;
    logic                  r_out_valid;
    logic [WORD_WIDTH-1:0] r_out_data;
    logic [WORD_WIDTH-1:0] r_skid_data;

    logic                  w_in;
    logic                  w_out;
    logic                  w_load_out_up;
    logic                  w_load_out_skid;
    logic                  w_load_skid;

    assign w_in  = up_valid & r_up_ready;
    assign w_out = r_out_valid & down_ready;

    always_comb begin
        w_state_next    = r_state;
        w_load_out_up   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in) begin
                    w_load_out_up = 1'b1;
                    w_state_next  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_in && !w_out) begin
                    w_load_skid  = 1'b1;
                    w_state_next = ST_FULL;
                end else if (w_in && w_out) begin
                    w_load_out_up = 1'b1;
                end else if (!w_in && w_out) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // up_ready is low here, so only the skid word can move forward
                if (down_ready) begin
                    w_load_out_skid = 1'b1;
                    w_state_next    = ST_BUSY;
                end
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_up_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            // Flags are registered from the next state so they track r_state
            r_up_ready  <= (w_state_next != ST_FULL);
            r_out_valid <= (w_state_next != ST_EMPTY);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_skid_data <= '0;
        end else begin
            if (w_load_out_up) begin
                r_out_data <= up_data;
            end else if (w_load_out_skid) begin
                r_out_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_data <= up_data;
            end
        end
    end

    assign up_ready   = r_up_ready;
    assign down_valid = r_out_valid;
    assign down_data  = r_out_data;
    assign occupancy  = r_state;

`else

    logic                  r_skid_valid;
    logic [WORD_WIDTH-1:0] r_skid_data;
    logic                  r_up_ready;

    logic                  w_capture;
    logic                  w_drain;
    logic                  w_skid_valid_next;

    // Capture the accepted word only when the consumer cannot take it now;
    // capture and drain are mutually exclusive since up_ready is low while
    // the skid is full.
    assign w_capture         = up_valid & r_up_ready & ~down_ready;
    assign w_drain           = r_skid_valid & down_ready;
    assign w_skid_valid_next = w_capture | (r_skid_valid & ~w_drain);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_up_ready   <= 1'b0;
        end else begin
            r_skid_valid <= w_skid_valid_next;
            r_up_ready   <= ~w_skid_valid_next;
            if (w_capture) begin
                r_skid_data <= up_data;
            end
        end
    end

    assign up_ready   = r_up_ready;
    assign down_valid = r_skid_valid | up_valid;
    assign down_data  = r_skid_valid ? r_skid_data : up_data;
    assign occupancy  = {1'b0, r_skid_valid};

`endif

endmodule
`default_nettype wire

// File: tb/tb_handshake_ready_skid.sv
`default_nettype none
// ============================================================================
//  Module      : tb_handshake_ready_skid
//  Description : Self-checking bench for handshake_ready_skid. A monitor
//                pushes every accepted upstream word into a queue and pops /
//                compares on every downstream transfer; scenario tasks add
//                cycle-exact checks for reset, streaming, stall, alternating
//                ready and mid-operation reset. Works with HS_SKID_FWD_REG_EN
//                defined or undefined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_handshake_ready_skid;

`ifdef HS_SKID_FWD_REG_EN
    localparam bit FWD_REG = 1'b1;
`else
    localparam bit FWD_REG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up_valid = 1'b0;
    logic [7:0] up_data = 8'h00;
    logic       up_ready;
    logic       down_valid;
    logic [7:0] down_data;
    logic       down_ready = 1'b0;
    logic [1:0] occupancy;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] sb[$];
    logic [7:0] exp_word;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    handshake_ready_skid #(.WORD_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_data    (up_data),
        .up_ready   (up_ready),
        .down_valid (down_valid),
        .down_data  (down_data),
        .down_ready (down_ready),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    // Monitor: sampled at negedge, i.e. the values the next posedge will see.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                vectors++;
                if (down_valid !== 1'b1 || down_data !== prev_data) begin
                    miscompares++;
                    $display("FAIL stable_hold: got valid=%b data=%h, required valid=1 data=%h",
                             down_valid, down_data, prev_data);
                end
            end
            if (up_valid && up_ready) sb.push_back(up_data);
            if (down_valid && down_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL scoreboard: got unexpected word %h, required none", down_data);
                end else begin
                    exp_word = sb.pop_front();
                    if (down_data !== exp_word) begin
                        miscompares++;
                        $display("FAIL scoreboard: got %h, required %h", down_data, exp_word);
                    end
                end
            end
            prev_hold = down_valid && !down_ready;
            prev_data = down_data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; up_valid = 1'b1; up_data = 8'hAA; down_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (up_ready !== 1'b0 || occupancy !== 2'd0) begin
                miscompares++;
                $display("FAIL reset_state: got up_ready=%b occ=%0d, required 0 0", up_ready, occupancy);
            end
            if (FWD_REG) begin
                vectors++;
                if (down_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_down_valid: got %b, required 0", down_valid);
                end
            end
            tick();
        end
        rst = 1'b0; up_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (up_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_early: got up_ready=%b, required 0", up_ready);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (up_ready !== 1'b1 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL reset_release: got up_ready=%b queued=%0d, required 1 0", up_ready, sb.size());
        end
        tick();
    endtask

    task automatic test_stream();
        logic       ev;
        logic [7:0] ed;
        down_ready = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            up_valid = (k < 16);
            up_data  = 8'(k + 1);
            if (FWD_REG) begin ev = (k >= 1); ed = 8'(k); end
            else         begin ev = (k < 16); ed = 8'(k + 1); end
            @(negedge clk);
            vectors++;
            if (down_valid !== ev || (ev && down_data !== ed) || up_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL stream k=%0d: got valid=%b data=%h ready=%b, required valid=%b data=%h ready=1",
                         k, down_valid, down_data, up_ready, ev, ed);
            end
            tick();
        end
        up_valid = 1'b0;
        tick();
        @(negedge clk);
        vectors++;
        if (sb.size() != 0 || down_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_drain: got queued=%0d valid=%b, required 0 0", sb.size(), down_valid);
        end
        tick();
    endtask

    // Fill the buffer with 0x21,0x22 while the consumer stalls.
    task automatic fill_stalled();
        logic acc;
        down_ready = 1'b0; up_valid = 1'b1; up_data = 8'h21;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            acc = up_valid && up_ready;
            tick();
            if (acc) begin
                if (up_data == 8'h21) up_data = 8'h22;
                else                  up_valid = 1'b0;
            end
        end
    endtask

    task automatic test_stall();
        logic acc;
        logic done;
        fill_stalled();
        @(negedge clk);
        vectors++;
        if (occupancy !== (FWD_REG ? 2'd2 : 2'd1) || up_ready !== 1'b0 ||
            down_valid !== 1'b1 || down_data !== 8'h21) begin
            miscompares++;
            $display("FAIL stall_state: got occ=%0d ready=%b valid=%b data=%h, required occ=%0d ready=0 valid=1 data=21",
                     occupancy, up_ready, down_valid, down_data, FWD_REG ? 2 : 1);
        end
        tick();
        down_ready = 1'b1;
        done = 1'b0;
        for (int r = 0; r < 10 && !done; r++) begin
            @(negedge clk);
            if (r == 0) begin
                vectors++;
                if (down_data !== 8'h21) begin
                    miscompares++;
                    $display("FAIL stall_release_first: got %h, required 21", down_data);
                end
            end
            if (!up_valid && sb.size() == 0 && !down_valid) done = 1'b1;
            acc = up_valid && up_ready;
            tick();
            if (acc) up_valid = 1'b0;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL stall_drain: got queued=%0d, required 0 within 10 cycles", sb.size());
        end
    endtask

    task automatic test_alternate();
        logic acc;
        int   sent = 0;
        int   cyc = 0;
        logic done;
        up_valid = 1'b0;
        down_ready = 1'b0;
        while (sent < 200 && cyc < 3000) begin
            @(negedge clk);
            acc = up_valid && up_ready;
            if (acc) sent++;
            tick();
            cyc++;
            down_ready = ~down_ready;
            if (!up_valid || acc) begin
                up_valid = (sent < 200) && ($urandom_range(0, 3) != 0);
                up_data  = 8'($urandom_range(0, 255));
            end
        end
        vectors++;
        if (sent < 200) begin
            miscompares++;
            $display("FAIL alternate_send: got %0d words accepted, required 200", sent);
        end
        up_valid = 1'b0;
        down_ready = 1'b1;
        done = 1'b0;
        for (int r = 0; r < 20 && !done; r++) begin
            @(negedge clk);
            if (sb.size() == 0 && !down_valid) done = 1'b1;
            tick();
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL alternate_drain: got queued=%0d, required 0", sb.size());
        end
    endtask

    task automatic test_mid_reset();
        fill_stalled();
        rst = 1'b1; up_valid = 1'b1; up_data = 8'h55;
        tick();
        rst = 1'b0; up_valid = 1'b0; down_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (occupancy !== 2'd0 || down_valid !== 1'b0 || up_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_state: got occ=%0d valid=%b ready=%b, required 0 0 0",
                     occupancy, down_valid, up_ready);
        end
        tick();
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            vectors++;
            if (down_valid !== 1'b0 || up_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL mid_reset_flush r=%0d: got valid=%b data=%h ready=%b, required valid=0 ready=1",
                         r, down_valid, down_data, up_ready);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_alternate();
        test_stream();
        test_mid_reset();
        test_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
